// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector for switches and push buttons.
// Each channel is synchronised to clk and debounced on a prescaled sample tick.
// A per-channel FSM then emits a one-clk pulse on the edge type selected by mode.
// The optional event counters are built when MULTI_EDGE_DETECTOR_COUNT_EN is defined.
module multi_edge_detector #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TICK_DIV       = 2500000,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       din,
  input  logic [1:0]                mode,
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
  input  logic                      count_clr,
  output logic [CHANNELS*CNT_W-1:0] count,
`endif
  output logic                      tick,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       pulse
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {StLow, StRise, StHigh, StFall} state_e;

  if (SYNC_STAGES < 2 || TICK_DIV < 1 || DEBOUNCE_TICKS < 1 || CNT_W < 1) begin : g_bad_param
    $error("multi_edge_detector: illegal parameter value");
  end

  logic [PW-1:0]                       r_presc, w_presc_nxt;
  logic                                r_tick;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                 w_sync;
  logic [DW-1:0]                       r_db [CHANNELS];
  logic [DW-1:0]                       w_db_nxt [CHANNELS];
  logic [CHANNELS-1:0]                 r_level, w_level_nxt;
  state_e                              r_state [CHANNELS];
  state_e                              w_state_nxt [CHANNELS];
  logic [CHANNELS-1:0]                 r_pulse, w_pulse_nxt;
  logic                                w_rise_en, w_fall_en;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_rise_en = ~mode[0];           // 00 or 10
  assign w_fall_en = mode[0] ^ mode[1];  // 01 or 10

  // Prescaler next count; tick is registered so it is 0 during reset even for TICK_DIV=1.
  always_comb begin
    w_presc_nxt = r_presc + 1'b1;
    if (r_presc == PW'(TICK_DIV - 1)) begin
      w_presc_nxt = '0;
    end
  end

  // Prescaler, tick strobe and synchroniser chains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_sync  <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      r_tick  <= (w_presc_nxt == PW'(TICK_DIV - 1));
      r_sync  <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce: count consecutive differing ticks, flip level when the count completes.
  always_comb begin
    w_db_nxt    = r_db;
    w_level_nxt = r_level;
    if (r_tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_sync[i] == r_level[i]) begin
          w_db_nxt[i] = '0;
        end else if (r_db[i] == DW'(DEBOUNCE_TICKS - 1)) begin
          w_db_nxt[i]    = '0;
          w_level_nxt[i] = ~r_level[i];
        end else begin
          w_db_nxt[i] = r_db[i] + 1'b1;
        end
      end
    end
  end

  // Channel FSM next state and registered pulse selection.
  always_comb begin
    w_pulse_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        StLow:   if (r_level[i]) w_state_nxt[i] = StRise;
        StRise:  w_state_nxt[i] = r_level[i] ? StHigh : StFall;
        StHigh:  if (!r_level[i]) w_state_nxt[i] = StFall;
        StFall:  w_state_nxt[i] = r_level[i] ? StRise : StLow;
        default: w_state_nxt[i] = StLow;
      endcase
      w_pulse_nxt[i] = ((w_state_nxt[i] == StRise) & w_rise_en) |
                       ((w_state_nxt[i] == StFall) & w_fall_en);
    end
  end

  // Debounce counters, levels, channel FSMs and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_db[i]    <= '0;
        r_state[i] <= StLow;
      end
      r_level <= '0;
      r_pulse <= '0;
    end else begin
      r_db    <= w_db_nxt;
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign tick  = r_tick;
  assign level = r_level;
  assign pulse = r_pulse;

`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] r_cnt [CHANNELS];

  // Saturating per-channel pulse counters; clear beats a coincident pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (count_clr) begin
          r_cnt[i] <= '0;
        end else if (r_pulse[i] && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    count = '0;
    for (int i = 0; i < CHANNELS; i++) count[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector (TICK_DIV=4, DEBOUNCE_TICKS=3, CNT_W=2).
module tb_multi_edge_detector;

  localparam int CH = 4;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] din;
  logic [1:0]    mode;
  logic          tick;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
  logic          count_clr;
  logic [CH*2-1:0] count;
`endif

  multi_edge_detector #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (2),
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .CNT_W         (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .mode     (mode),
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
    .count_clr(count_clr),
    .count    (count),
`endif
    .tick     (tick),
    .level    (level),
    .pulse    (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int       ch;
    logic [1:0] mode;
    int       hold;
    int       exp_rose;
    int       exp_np;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, cons, ticks, found, bad, rose, np, other;
    int c0, c1, p0, p1;
    logic lv, lv1, lv2, pl, ex, prev_t;
    logic [CH-1:0] mask;

    // ch, mode, hold cycles, expect level rise, expect pulse count
    vecs[0] = '{0, 2'b00, 40, 1, 1};
    vecs[1] = '{1, 2'b00,  8, 0, 0};
    vecs[2] = '{2, 2'b10, 40, 1, 2};
    vecs[3] = '{3, 2'b11, 40, 1, 0};
    vecs[4] = '{3, 2'b01, 40, 1, 1};
    vecs[5] = '{1, 2'b10,  4, 0, 0};
    vecs[6] = '{0, 2'b10, 16, 1, 2};

    din   = '0;
    mode  = 2'b00;
    rst_n = 1'b1;
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
    count_clr = 1'b0;
`endif
    #2 rst_n = 1'b0;
    idle(3);
    check("reset_tick", int'(tick), 0);
    check("reset_level", int'(level), 0);
    check("reset_pulse", int'(pulse), 0);

    // Tick timing after release: first strobe on the third edge, then every 4 cycles.
    rst_n = 1'b1;
    first = -1; ticks = 0; cons = 0; prev_t = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick && first < 0) first = k;
      if (tick) ticks++;
      if (tick && prev_t) cons++;
      prev_t = tick;
    end
    check("tick_first", first, 3);
    check("tick_count", ticks, 10);
    check("tick_width", cons, 0);

    // Rise latency on channel 0.
    din[0] = 1'b1;
    n = 0;
    while (!level[0] && n < 30) begin
      step();
      n++;
    end
    check("latency_in_window", int'(n >= 10 && n <= 14), 1);
    din[0] = 1'b0;
    idle(40);

    // Table-driven single-channel scenarios.
    foreach (vecs[v]) begin
      mode = vecs[v].mode;
      mask = CH'(1) << vecs[v].ch;
      lv1 = level[vecs[v].ch];
      lv2 = lv1;
      bad = 0; rose = 0; np = 0; other = 0;
      din[vecs[v].ch] = 1'b1;
      for (int c = 0; c < vecs[v].hold + 45; c++) begin
        if (c == vecs[v].hold) din[vecs[v].ch] = 1'b0;
        step();
        lv = level[vecs[v].ch];
        pl = pulse[vecs[v].ch];
        ex = (lv1 & ~lv2 & ~mode[0]) | (~lv1 & lv2 & (mode[0] ^ mode[1]));
        if (pl !== ex) bad++;
        if (lv) rose = 1;
        if (pl) np++;
        if ((pulse & ~mask) != '0) other++;
        lv2 = lv1;
        lv1 = lv;
      end
      check($sformatf("vec%0d_rose", v), rose, vecs[v].exp_rose);
      check($sformatf("vec%0d_npulse", v), np, vecs[v].exp_np);
      check($sformatf("vec%0d_pulse_timing", v), bad, 0);
      check($sformatf("vec%0d_other_quiet", v), other, 0);
      check($sformatf("vec%0d_final_level", v), int'(level[vecs[v].ch]), 0);
    end

    // Mode 11 suppresses pulses while level still follows; mode 01 then catches the fall.
    mode = 2'b11;
    din[3] = 1'b1;
    np = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (pulse != '0) np++;
    end
    check("mode11_level", int'(level[3]), 1);
    check("mode11_no_pulse", np, 0);
    mode = 2'b01;
    din[3] = 1'b0;
    np = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (pulse[3]) np++;
    end
    check("mode01_fall_pulse", np, 1);
    idle(10);

    // Reset while pulse[0] is high.
    mode = 2'b00;
    din[1:0] = 2'b11;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (pulse[0]) found = 1;
    end
    check("wait_pulse0", found, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_level", int'(level), 0);
    check("async_rst_pulse", int'(pulse), 0);
    idle(2);
    rst_n = 1'b1;
    c0 = 0; c1 = 0; p0 = -1; p1 = -2;
    for (int k = 0; k < 60; k++) begin
      step();
      if (pulse[0]) begin c0++; p0 = k; end
      if (pulse[1]) begin c1++; p1 = k; end
    end
    check("post_rst_pulse0", c0, 1);
    check("post_rst_pulse1", c1, 1);
    check("simultaneous_pulse", p0, p1);

    // Reset mid-debounce on channel 2 must clear the partial count.
    din[2] = 1'b1;
    idle(9);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    din[2] = 1'b0;
    rose = 0; np = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (level[2]) rose = 1;
      if (pulse[2]) np++;
    end
    check("mid_debounce_no_level", rose, 0);
    check("mid_debounce_no_pulse", np, 0);
    din = '0;
    idle(40);

`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    check("count_cleared", int'(count[1:0]), 0);
    for (int e = 0; e < 5; e++) begin
      din[0] = 1'b1;
      idle(20);
      din[0] = 1'b0;
      idle(20);
      if (e == 0) check("count_one", int'(count[1:0]), 1);
    end
    check("count_saturate", int'(count[1:0]), 3);
    din[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (pulse[0]) found = 1;
    end
    check("wait_pulse0_clr", found, 1);
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    check("count_clr_wins", int'(count[1:0]), 0);
    din[0] = 1'b0;
    idle(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
